if_prefetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the decode stage.
- Owns the fetch PC and issues word reads to instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned instructions, with their PC and PC+4, in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Branch, jump and interrupt redirects flush the queue, discard any in-flight read, and restart fetch at the new PC.

---
 rtl/if_prefetch_queue_if.sv | 29 ++
 rtl/if_prefetch_queue.sv | 119 +++++++++++
 2 files changed

// File: rtl/if_prefetch_queue_if.sv
// Bundles the redirect, instruction-memory and decode-side signals of the prefetch queue.
// The master modport is the queue itself; the slave modport is its environment.
interface if_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_ins;
  logic [31:0]       id_pc;
  logic [31:0]       id_pcp4;
  logic [CountW-1:0] count;

  modport master (
    input  redirect, redirect_pc, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_ins, id_pc, id_pcp4, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_ins, id_pc, id_pcp4, count
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency memory reads and
// queues returned words with their PC for decode; redirects flush and restart fetch.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  reset,
  if_prefetch_queue_if.master   bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam logic [CountW:0] DepthW = (CountW+1)'(DEPTH);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CountW-1:0] count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       fifo_ins_q [DEPTH];
  logic [31:0]       fifo_ins_d [DEPTH];
  logic [31:0]       fifo_pc_q  [DEPTH];
  logic [31:0]       fifo_pc_d  [DEPTH];

  logic [CountW:0] credit_used;
  logic            issue;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic            valid;

  // Credit counts the in-flight read so a response always has a free slot; pops are ignored.
  assign credit_used = {1'b0, count_q} + {{CountW{1'b0}}, inflight_q};
  assign issue       = !reset && !bus.redirect && (credit_used < DepthW);
  assign resp_ok     = inflight_q && (req_epoch_q == epoch_q);
  assign push        = resp_ok && !reset && !bus.redirect;
  assign valid       = !reset && (count_q != '0);
  assign pop         = valid && bus.id_ready;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.id_valid  = valid;
  assign bus.id_ins    = fifo_ins_q[head_q];
  assign bus.id_pc     = fifo_pc_q[head_q];
  assign bus.id_pcp4   = fifo_pc_q[head_q] + 32'd4;
  assign bus.count     = count_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    req_addr_d  = req_addr_q;
    fifo_ins_d  = fifo_ins_q;
    fifo_pc_d   = fifo_pc_q;

    if (reset) begin
      fetch_pc_d = RESET_PC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      epoch_d    = 1'b0;
    end else if (bus.redirect) begin
      // Toggling the epoch orphans any read still returning after the flush.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      epoch_d    = ~epoch_q;
    end else begin
      if (push) begin
        fifo_ins_d[tail_q] = bus.imem_rdata;
        fifo_pc_d[tail_q]  = req_addr_q;
        tail_d             = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountW'(1);
        2'b01:   count_d = count_q - CountW'(1);
        default: count_d = count_q;
      endcase
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d  = fetch_pc_q + 32'd4;
        req_epoch_d = epoch_q;
        req_addr_d  = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q  <= fetch_pc_d;
    head_q      <= head_d;
    tail_q      <= tail_d;
    count_q     <= count_d;
    inflight_q  <= inflight_d;
    epoch_q     <= epoch_d;
    req_epoch_q <= req_epoch_d;
    req_addr_q  <= req_addr_d;
  end

  // Storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    fifo_ins_q <= fifo_ins_d;
    fifo_pc_q  <= fifo_pc_d;
  end

endmodule
